// File: rtl/led_pwm_array_if.sv
// ---------------------------------------------------------------------------
// led_pwm_array_if
// Processor-side command bus for the LED PWM array.
//   led_commands : NUM_LEDS*CMD_W packed channel commands, channel i at
//                  [i*CMD_W +: CMD_W]
//   cmd_update   : one-cycle strobe asking the array to capture led_commands
// The processor side uses the master modport; the LED array uses slave.
// ---------------------------------------------------------------------------
interface led_pwm_array_if #(
  parameter int NUM_LEDS = 18,
  parameter int CMD_W    = 8
);
  logic [NUM_LEDS*CMD_W-1:0] led_commands;
  logic                      cmd_update;

  modport master (
    output led_commands,
    output cmd_update
  );

  modport slave (
    input led_commands,
    input cmd_update
  );
endinterface

// File: rtl/led_pwm_array.sv
// ---------------------------------------------------------------------------
// led_pwm_array
// N-channel LED driver. Each channel command selects off, steady on,
// PWM-dimmed or blinking-and-dimmed output. Commands are captured into a
// shadow register and only become active at a PWM period boundary, so a
// processor write never produces a glitch inside a period.
// Ports:
//   clock          : system clock, rising edge
//   reset          : synchronous, active-high
//   bus (slave)    : led_commands / cmd_update from the processor
//   led_pins       : registered LED drive, 1 = lit
//   period_start   : one-cycle pulse in the cycle after the PWM counter wraps
//   update_pending : shadow holds a command not yet committed
// Command layout: mode = cmd[CMD_W-1:CMD_W-2], duty = cmd[CMD_W-3:0].
//   00 off, 01 steady on, 10 PWM (lit while pwm_cnt < duty),
//   11 blink (lit while blink phase is high and pwm_cnt < duty).
// ---------------------------------------------------------------------------
module led_pwm_array #(
  parameter int NUM_LEDS      = 18,
  parameter int CMD_W         = 8,
  parameter int PRESCALE      = 1,
  parameter int BLINK_PERIODS = 8
) (
  input  logic                clock,
  input  logic                reset,
  led_pwm_array_if.slave      bus,
  output logic [NUM_LEDS-1:0] led_pins,
  output logic                period_start,
  output logic                update_pending
);

  localparam int DW = CMD_W - 2;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int CW = NUM_LEDS * CMD_W;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_PWM   = 2'b10;

  logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [CW-1:0]       shadow_q, shadow_d;
  logic [CW-1:0]       active_q, active_d;
  logic                pending_q, pending_d;
  logic [NUM_LEDS-1:0] pins_q, pins_d;
  logic                period_start_q, period_start_d;

  logic tick;
  logic wrap;

  assign tick = (pre_cnt_q == PW'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt_q == {DW{1'b1}});

  // Duty compare is strict, so a full-scale duty still leaves one dark tick;
  // steady mode is the only way to get a permanently lit pin.
  function automatic logic decode(input logic [CMD_W-1:0] cmd,
                                  input logic [DW-1:0]    cnt,
                                  input logic             phase);
    logic litPwm;
    litPwm = (cnt < cmd[DW-1:0]);
    case (cmd[CMD_W-1:CMD_W-2])
      MODE_OFF:    decode = 1'b0;
      MODE_STEADY: decode = 1'b1;
      MODE_PWM:    decode = litPwm;
      default:     decode = phase && litPwm;
    endcase
  endfunction

  // Prescaler, PWM counter and blink timebase.
  always_comb begin
    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (blink_cnt_q == BW'(BLINK_PERIODS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Double buffering. A strobe landing on the wrap edge bypasses the shadow
  // so the new command takes effect at the very next period; otherwise the
  // latest strobe wins and is committed at the following wrap.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bus.cmd_update && wrap) begin
      active_d  = bus.led_commands;
      shadow_d  = bus.led_commands;
      pending_d = 1'b0;
    end else if (bus.cmd_update) begin
      shadow_d  = bus.led_commands;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Pin decode from the current counter and active commands, registered.
  always_comb begin
    pins_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pins_d[i] = decode(active_q[i*CMD_W +: CMD_W], pwm_cnt_q, blink_phase_q);
    end
    period_start_d = wrap;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pins_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pins_q         <= pins_d;
      period_start_q <= period_start_d;
    end
  end

  assign led_pins       = pins_q;
  assign period_start   = period_start_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_led_pwm_array.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_array
// Directed bench for led_pwm_array. A fast instance (PRESCALE=1) is checked
// cycle by cycle against expected pin patterns queued per PWM period; a slow
// instance (PRESCALE=4) sharing the same bus is spot-checked for the stretched
// timebase during the blink sequence.
// ---------------------------------------------------------------------------
module tb_led_pwm_array;

  localparam int NL = 4;
  localparam int CW = 8;

  logic          clock;
  logic          reset;
  logic [NL-1:0] pins;
  logic          ps;
  logic          pend;
  logic [NL-1:0] pins4;
  logic          ps4;
  logic          pend4;

  int checks   = 0;
  int failures = 0;
  int edgeN    = 0;
  bit slowArmed = 1'b0;

  logic [NL-1:0] expQ[$];

  led_pwm_array_if #(.NUM_LEDS(NL), .CMD_W(CW)) bus ();

  led_pwm_array #(.NUM_LEDS(NL), .CMD_W(CW), .PRESCALE(1), .BLINK_PERIODS(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .led_pins       (pins),
    .period_start   (ps),
    .update_pending (pend)
  );

  led_pwm_array #(.NUM_LEDS(NL), .CMD_W(CW), .PRESCALE(4), .BLINK_PERIODS(2)) dut4 (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .led_pins       (pins4),
    .period_start   (ps4),
    .update_pending (pend4)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Number of rising edges since reset was released.
  always @(posedge clock) begin
    if (reset) edgeN <= 0;
    else       edgeN <= edgeN + 1;
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] cmds, input logic upd);
    bus.led_commands = cmds;
    bus.cmd_update   = upd;
  endtask

  // Spot checks on the PRESCALE=4 instance, keyed on edges since release.
  task automatic checkSlow();
    case (edgeN)
      255:  checkOutput("slow_ps_before_wrap", {31'd0, ps4}, 32'd0);
      256:  checkOutput("slow_ps_wrap", {31'd0, ps4}, 32'd1);
      300:  checkOutput("slow_blink_off_p1", {31'd0, pins4[2]}, 32'd0);
      520:  checkOutput("slow_blink_on_p2", {31'd0, pins4[2]}, 32'd1);
      1020: checkOutput("slow_blink_on_p3", {31'd0, pins4[2]}, 32'd1);
      1024: checkOutput("slow_blink_dark_tick", {31'd0, pins4[2]}, 32'd0);
      1030: checkOutput("slow_blink_off_p4", {31'd0, pins4[2]}, 32'd0);
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge clock);
    if (slowArmed) checkSlow();
  endtask

  // Advance until period_start is seen, bounded.
  task automatic waitPeriod(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ps && n < 300);
    if (!ps) checkOutput({tag, "_period_timeout"}, {31'd0, ps}, 32'd1);
  endtask

  // Queue one period of expected pins: channel i lit for the first onN ticks.
  task automatic pushPeriod(input int on0, input int on1, input int on2, input int on3);
    logic [NL-1:0] e;
    for (int j = 0; j < 64; j++) begin
      e[0] = (j < on0);
      e[1] = (j < on1);
      e[2] = (j < on2);
      e[3] = (j < on3);
      expQ.push_back(e);
    end
  endtask

  // Called at a period_start sample point (pwm_cnt is 0 in this cycle).
  // Checks the 64 pin samples of this period against the queue and can fire
  // up to two cmd_update strobes captured while pwm_cnt equals updA / updB.
  task automatic checkPeriod(input string tag,
                             input int updA, input logic [31:0] cmdA,
                             input int updB, input logic [31:0] cmdB);
    int drivenAt;
    logic [NL-1:0] e;
    drivenAt = -1;
    if (updA == 0) begin
      applyStimulus(cmdA, 1'b1);
      drivenAt = 0;
    end
    for (int j = 0; j < 64; j++) begin
      tick();
      e = expQ.pop_front();
      checkOutput($sformatf("%s_pins_%0d", tag, j), {28'd0, pins}, {28'd0, e});
      if (drivenAt >= 0) begin
        bus.cmd_update = 1'b0;
        checkOutput($sformatf("%s_pending_%0d", tag, j), {31'd0, pend},
                    {31'd0, (drivenAt != 63)});
        drivenAt = -1;
      end
      if (j + 1 == updA) begin
        applyStimulus(cmdA, 1'b1);
        drivenAt = j + 1;
      end else if (j + 1 == updB) begin
        applyStimulus(cmdB, 1'b1);
        drivenAt = j + 1;
      end
    end
    checkOutput({tag, "_ps_end"}, {31'd0, ps}, 32'd1);
    checkOutput({tag, "_pending_end"}, {31'd0, pend}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("rst_pins", {28'd0, pins}, 32'd0);
    checkOutput("rst_ps", {31'd0, ps}, 32'd0);
    checkOutput("rst_pending", {31'd0, pend}, 32'd0);

    // Commit ch1 steady so the pins are visibly lit before the mid-period reset.
    reset = 1'b0;
    applyStimulus(32'h0000_4000, 1'b1);
    tick();
    bus.cmd_update = 1'b0;
    checkOutput("init_pending", {31'd0, pend}, 32'd1);
    waitPeriod("init");
    checkOutput("init_first_wrap_edge", edgeN, 32'd64);
    repeat (20) tick();
    checkOutput("init_pins_ch1", {28'd0, pins}, 32'h2);

    // Reset mid-period with an update pending; strobes during reset are ignored.
    applyStimulus(32'h0000_4040, 1'b1);
    tick();
    bus.cmd_update = 1'b0;
    checkOutput("t1_pending_before_reset", {31'd0, pend}, 32'd1);
    reset = 1'b1;
    applyStimulus(32'h0000_0040, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t1_rst_pins_%0d", i), {28'd0, pins}, 32'd0);
      checkOutput($sformatf("t1_rst_ps_%0d", i), {31'd0, ps}, 32'd0);
      checkOutput($sformatf("t1_rst_pending_%0d", i), {31'd0, pend}, 32'd0);
    end
    reset = 1'b0;
    applyStimulus(32'h0, 1'b0);
    waitPeriod("t1");
    checkOutput("t1_first_wrap_edge", edgeN, 32'd64);

    // Load ch0 PWM D=16, ch1 steady; nothing lit until the commit.
    pushPeriod(0, 0, 0, 0);
    checkPeriod("t2_load", 10, 32'h0000_4090, -1, 32'h0);
    pushPeriod(16, 64, 0, 0);
    checkPeriod("t2_run", -1, 32'h0, -1, 32'h0);

    // Mid-period duty change 16 -> 48 keeps the old duty for this period.
    pushPeriod(16, 64, 0, 0);
    checkPeriod("t3_update", 20, 32'h0000_40B0, -1, 32'h0);

    // Strobe on the wrap cycle itself: no pending, active next period.
    pushPeriod(48, 64, 0, 0);
    checkPeriod("t4_wrap_update", 63, 32'h0000_4088, -1, 32'h0);

    // Two strobes in one period: the later one wins.
    pushPeriod(8, 64, 0, 0);
    checkPeriod("t5_double", 5, 32'h0000_408A, 30, 32'h0000_409E);
    pushPeriod(30, 64, 0, 0);
    checkPeriod("t5_result", -1, 32'h0, -1, 32'h0);

    // Blink with BLINK_PERIODS=2 from a fresh reset.
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    applyStimulus(32'h00FF_0000, 1'b1);
    slowArmed = 1'b1;
    tick();
    bus.cmd_update = 1'b0;
    waitPeriod("t6");
    pushPeriod(0, 0, 0, 0);
    checkPeriod("t6_p1_off", -1, 32'h0, -1, 32'h0);
    pushPeriod(0, 0, 63, 0);
    checkPeriod("t6_p2_on", -1, 32'h0, -1, 32'h0);
    pushPeriod(0, 0, 63, 0);
    checkPeriod("t6_p3_on", -1, 32'h0, -1, 32'h0);
    pushPeriod(0, 0, 0, 0);
    checkPeriod("t6_p4_off", -1, 32'h0, -1, 32'h0);
    for (int i = 0; i < 2000 && edgeN < 1031; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
